// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data-memory arbiter between CPU MEM stage and DMA port (DMEM_ARB_PERF_EN adds perf counters)
// Each access runs IDLE -> ISSUE -> WAIT(MEM_LAT) -> DONE; CPU is favoured until DMA has starved STARVE_LIMIT grants.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              stall,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]       perf_stall_cycles,
    output logic [15:0]       perf_dma_grants,
`endif
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WCNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int SCNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(MEM_LAT - 1);
    localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                owner_dma_q, owner_dma_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [SCNT_W-1:0]   starve_q, starve_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_dma_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wcnt_q      <= '0;
            starve_q    <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_dma_q <= owner_dma_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wcnt_q      <= wcnt_d;
            starve_q    <= starve_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_dma_d = owner_dma_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wcnt_d      = wcnt_q;
        starve_d    = starve_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (dma_req && (starve_q == STARVE_MAX || !cpu_req)) begin
                    owner_dma_d = 1'b1;
                    we_d        = dma_we;
                    addr_d      = dma_addr;
                    wdata_d     = dma_wdata;
                    starve_d    = '0;
                    state_d     = S_ISSUE;
                end else if (cpu_req) begin
                    owner_dma_d = 1'b0;
                    we_d        = cpu_we;
                    addr_d      = cpu_addr;
                    wdata_d     = cpu_wdata;
                    state_d     = S_ISSUE;
                    // Counter only advances while DMA is actually being passed over.
                    if (!dma_req)
                        starve_d = '0;
                    else if (starve_q != STARVE_MAX)
                        starve_d = starve_q + SCNT_W'(1);
                end
            end
            S_ISSUE: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (owner_dma_q)
                            dma_rdata_d = mem_rdata;
                        else
                            cpu_rdata_d = mem_rdata;
                    end
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = (state_q == S_ISSUE) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ready = (state_q == S_DONE) && !owner_dma_q;
    assign dma_ack   = (state_q == S_DONE) && owner_dma_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    // Released during DONE so EX/MEM and MEM/WB advance on the completing edge.
    assign stall     = cpu_req && !cpu_ready;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_stall_q;
    logic [15:0] perf_dma_q;
    logic        dma_grant;

    assign dma_grant = (state_q == S_IDLE) && (state_d == S_ISSUE) && owner_dma_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_dma_q   <= '0;
        end else begin
            if (stall && (perf_stall_q != 32'hFFFF_FFFF))
                perf_stall_q <= perf_stall_q + 32'd1;
            if (dma_grant && (perf_dma_q != 16'hFFFF))
                perf_dma_q <= perf_dma_q + 16'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_dma_grants   = perf_dma_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter (MEM_LAT=1 and MEM_LAT=3 instances)
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        mem_init;
    int          n_checks;
    int          n_errors;

    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0]  cpu_addr, dma_addr;
    logic [31:0] cpu_wdata, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
    logic        cpu_ready, stall, dma_ack, mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem [256];

    logic        b_req;
    logic [7:0]  b_addr;
    logic [31:0] b_rdata, b_dma_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_ready, b_stall, b_dma_ack, b_mem_en, b_mem_we;
    logic [7:0]  b_mem_addr;
    logic [31:0] b_pipe [3];

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .stall(stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(4)) dut_lat3 (
        .clk(clk), .rst(rst),
        .cpu_req(b_req), .cpu_we(1'b0), .cpu_addr(b_addr), .cpu_wdata(32'h0),
        .cpu_rdata(b_rdata), .cpu_ready(b_ready), .stall(b_stall),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(8'h0), .dma_wdata(32'h0),
        .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, read data valid one cycle after the issue edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'(i * 3 + 1);
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    // Three-stage read pipeline returning C0DE0000|addr for the MEM_LAT=3 instance.
    always @(posedge clk) begin
        if (b_mem_en) b_pipe[0] <= 32'hC0DE_0000 | {24'h0, b_mem_addr};
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign b_mem_rdata = b_pipe[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cpu_op(input logic we, input logic [7:0] a, input logic [31:0] d, input string tag);
        int n;
        int en_at;
        logic [7:0] addr_seen;
        logic we_seen;
        bit stall_ok;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        n = 0; en_at = -1; stall_ok = 1'b1; addr_seen = 8'h0; we_seen = 1'b0;
        @(negedge clk);
        while (!cpu_ready && n < 20) begin
            if (mem_en && en_at < 0) begin
                en_at = n; addr_seen = mem_addr; we_seen = mem_we;
            end
            if (!stall) stall_ok = 1'b0;
            n++;
            @(negedge clk);
        end
        check({tag, "_ready_lat"}, n, 3);
        check({tag, "_en_at"}, en_at, 1);
        check({tag, "_mem_addr"}, {24'h0, addr_seen}, {24'h0, a});
        check({tag, "_mem_we"}, {31'h0, we_seen}, {31'h0, we});
        check({tag, "_stall_hi"}, {31'h0, stall_ok}, 32'd1);
        check({tag, "_stall_done"}, {31'h0, stall}, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic dma_op(input logic we, input logic [7:0] a, input logic [31:0] d, input string tag);
        int n;
        @(posedge clk); #1;
        dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
        n = 0;
        @(negedge clk);
        while (!dma_ack && n < 20) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_ack_lat"}, n, 3);
        check({tag, "_no_cpu_ready"}, {31'h0, cpu_ready}, 32'd0);
        @(posedge clk); #1;
        dma_req = 1'b0;
    endtask

    initial begin
        logic [9:0] seq;
        logic [9:0] seq_exp;
        int done_cnt;
        int cyc;
        int n;
        bit ready_seen;
        n_checks = 0; n_errors = 0;
        rst = 1'b1; mem_init = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h0; dma_wdata = 32'h0;
        b_req = 1'b0; b_addr = 8'h0;

        repeat (10) @(posedge clk);
        #1;
        check("rst_mem_en", {31'h0, mem_en}, 32'd0);
        check("rst_mem_addr", {24'h0, mem_addr}, 32'd0);
        rst = 1'b0; mem_init = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_mem_en", {31'h0, mem_en}, 32'd0);
            check("idle_cpu_ready", {31'h0, cpu_ready}, 32'd0);
            check("idle_dma_ack", {31'h0, dma_ack}, 32'd0);
            check("idle_stall", {31'h0, stall}, 32'd0);
            check("idle_cpu_rdata", cpu_rdata, 32'd0);
        end

        cpu_op(1'b1, 8'd20, 32'd20, "st20");
        check("st20_rdata_kept", cpu_rdata, 32'd0);
        cpu_op(1'b0, 8'd20, 32'd0, "ld20");
        check("ld20_rdata", cpu_rdata, 32'd20);

        // Both ports requesting continuously: DMA gets every fifth slot.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd20;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 8'd5;
        seq = '0; done_cnt = 0; cyc = 0;
        while (done_cnt < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cpu_ready && dma_ack) check("starve_both_pulse", 32'd1, 32'd0);
            if (cpu_ready || dma_ack) begin
                seq[done_cnt] = dma_ack;
                done_cnt++;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; dma_req = 1'b0;
        seq_exp = 10'b10_0001_0000;
        check("starve_done_cnt", done_cnt, 10);
        check("starve_pattern", {22'h0, seq}, {22'h0, seq_exp});
        check("starve_cpu_rdata", cpu_rdata, 32'd20);
        check("starve_dma_rdata", dma_rdata, 32'd16);

        dma_op(1'b1, 8'd7, 32'hA5, "dwr7");
        check("dwr7_dma_rdata_kept", dma_rdata, 32'd16);
        cpu_op(1'b0, 8'd7, 32'd0, "ld7");
        check("ld7_rdata", cpu_rdata, 32'hA5);
        check("ld7_dma_rdata", dma_rdata, 32'd16);

        // Reset in the WAIT cycle of a CPU load abandons it.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd5;
        @(negedge clk);
        @(negedge clk);
        check("rstw_issue_en", {31'h0, mem_en}, 32'd1);
        @(posedge clk); #2;
        rst = 1'b1; cpu_req = 1'b0;
        #1;
        check("rstw_cpu_ready", {31'h0, cpu_ready}, 32'd0);
        check("rstw_mem_en", {31'h0, mem_en}, 32'd0);
        check("rstw_cpu_rdata", cpu_rdata, 32'd0);
        check("rstw_stall", {31'h0, stall}, 32'd0);
        ready_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready) ready_seen = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ready) ready_seen = 1'b1;
        end
        check("rstw_no_ready", {31'h0, ready_seen}, 32'd0);
        cpu_op(1'b0, 8'd7, 32'd0, "post_rst");
        check("post_rst_rdata", cpu_rdata, 32'hA5);

        // MEM_LAT=3 instance: ready five cycles after the request is sampled.
        @(posedge clk); #1;
        b_req = 1'b1; b_addr = 8'd9;
        n = 0;
        @(negedge clk);
        while (!b_ready && n < 30) begin
            n++;
            @(negedge clk);
        end
        check("lat3_ready_lat", n, 5);
        check("lat3_rdata", b_rdata, 32'hC0DE_0009);
        check("lat3_stall_done", {31'h0, b_stall}, 32'd0);
        @(posedge clk); #1;
        b_req = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
